vga_timing_gen: RTL and testbench

//  Parametrised VGA timing generator and successor to the fixed 640x480 sync generator.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 26 ++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: the 640x480@60 default, an 800x600@72 preset,
// the default coordinate type and a helper that sums the four timing segments.
package vga_timing_pkg;

    localparam int VGA_CW = 10;
    typedef logic [VGA_CW-1:0] coord_t;

    // 640x480@60, 25 MHz pixel clock, negative syncs
    localparam int   VGA640_H_ACTIVE = 640;
    localparam int   VGA640_H_FP     = 16;
    localparam int   VGA640_H_SYNC   = 96;
    localparam int   VGA640_H_BP     = 48;
    localparam int   VGA640_V_ACTIVE = 480;
    localparam int   VGA640_V_FP     = 10;
    localparam int   VGA640_V_SYNC   = 2;
    localparam int   VGA640_V_BP     = 33;
    localparam logic VGA640_H_POL    = 1'b0;
    localparam logic VGA640_V_POL    = 1'b0;

    // 800x600@72, 50 MHz pixel clock, positive syncs
    localparam int   SVGA800_H_ACTIVE = 800;
    localparam int   SVGA800_H_FP     = 56;
    localparam int   SVGA800_H_SYNC   = 120;
    localparam int   SVGA800_H_BP     = 64;
    localparam int   SVGA800_V_ACTIVE = 600;
    localparam int   SVGA800_V_FP     = 37;
    localparam int   SVGA800_V_SYNC   = 6;
    localparam int   SVGA800_V_BP     = 23;
    localparam logic SVGA800_H_POL    = 1'b1;
    localparam logic SVGA800_V_POL    = 1'b1;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 while enabled; wrap flags the enabled
// cycle in which the count returns to 0.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with one registered output stage.
// Define VGA_PIX_CE_EN to add the pix_ce pixel clock enable port.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FP     = VGA640_H_FP,
    parameter int   H_SYNC   = VGA640_H_SYNC,
    parameter int   H_BP     = VGA640_H_BP,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FP     = VGA640_V_FP,
    parameter int   V_SYNC   = VGA640_V_SYNC,
    parameter int   V_BP     = VGA640_V_BP,
    parameter logic H_POL    = VGA640_H_POL,
    parameter logic V_POL    = VGA640_V_POL,
    parameter int   CW       = VGA_CW
) (
    input  logic          clk,
    input  logic          reset,
`ifdef VGA_PIX_CE_EN
    input  logic          pix_ce,
`endif
    output logic          h_sync,
    output logic          v_sync,
    output logic          onscreen,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_cw_check
            $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
        end
    endgenerate

    logic          ce;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap_unused;

`ifdef VGA_PIX_CE_EN
    assign ce = pix_ce;
`else
    assign ce = 1'b1;
`endif

    vga_axis_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_h_counter (
        .clk   (clk),
        .reset (reset),
        .en    (ce),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    // The vertical axis advances only on the horizontal wrap, so v_cnt
    // (and therefore vsync) changes exactly on the x==0 boundary.
    vga_axis_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_v_counter (
        .clk   (clk),
        .reset (reset),
        .en    (ce & h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap_unused)
    );

    logic h_sync_next;
    logic v_sync_next;
    logic onscreen_next;
    logic line_start_next;
    logic frame_start_next;

    always_comb begin
        onscreen_next    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        h_sync_next      = ((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END)) ? H_POL : ~H_POL;
        v_sync_next      = ((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END)) ? V_POL : ~V_POL;
        line_start_next  = (h_cnt == '0);
        frame_start_next = (h_cnt == '0) && (v_cnt == '0);
    end

    // x/y are registered alongside the decode so every pin describes the same pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            onscreen    <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            h_sync      <= h_sync_next;
            v_sync      <= v_sync_next;
            onscreen    <= onscreen_next;
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= line_start_next;
            frame_start <= frame_start_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default 640x480 instance (A) and a tiny active-high
// instance (B) checked against a linear-position reference model.
module tb_vga_timing_gen;

    localparam int BHA = 16, BHF = 2, BHS = 2, BHB = 2;
    localparam int BVA = 4,  BVF = 1, BVS = 1, BVB = 1;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;
    localparam int BCW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic ce_b;
`ifdef VGA_PIX_CE_EN
    logic ce_a;
`endif

    logic       hs_a, vs_a, on_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic           hs_b, vs_b, on_b, ls_b, fs_b;
    logic [BCW-1:0] x_b, y_b;

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .reset       (rst_a),
`ifdef VGA_PIX_CE_EN
        .pix_ce      (ce_a),
`endif
        .h_sync      (hs_a),
        .v_sync      (vs_a),
        .onscreen    (on_a),
        .x           (x_a),
        .y           (y_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .H_POL(1'b1), .V_POL(1'b1), .CW(BCW)
    ) u_dut_b (
        .clk         (clk),
        .reset       (rst_b),
`ifdef VGA_PIX_CE_EN
        .pix_ce      (ce_b),
`endif
        .h_sync      (hs_b),
        .v_sync      (vs_b),
        .onscreen    (on_b),
        .x           (x_b),
        .y           (y_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference for B: outputs after the edge that consumed position pos.
    function automatic logic [14:0] model_b(input int pos);
        int mx, my;
        logic on, hs, vs, ls, fs;
        mx = pos % BHT;
        my = pos / BHT;
        on = (mx < BHA) && (my < BVA);
        hs = (mx >= BHA + BHF) && (mx < BHA + BHF + BHS);
        vs = (my >= BVA + BVF) && (my < BVA + BVF + BVS);
        ls = (mx == 0);
        fs = (pos == 0);
        return {BCW'(mx), BCW'(my), on, hs, vs, ls, fs};
    endfunction

    localparam logic [14:0] B_RESET = {5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic logic [14:0] pack_b();
        return {x_b, y_b, on_b, hs_b, vs_b, ls_b, fs_b};
    endfunction

    typedef struct {
        int   pos;
        int   ex, ey;
        logic on, hs, vs, ls, fs;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int pos, last_ls, last_fs, n_ls, n_fs, hs_t, vs_t;
        logic p_hs, p_vs, p_on;
        logic [14:0] m_out;
        int m_pos;

        vecs[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{640,  640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{655,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{656,  656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{751,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{752,  752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{799,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1440, 640, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1600, 0,   2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        ce_b  = 1'b1;
`ifdef VGA_PIX_CE_EN
        ce_a  = 1'b1;
`endif
        repeat (3) step();

        // Reset state of both instances
        chk("a_rst_x", x_a, 0);       chk("a_rst_y", y_a, 0);
        chk("a_rst_on", on_a, 0);     chk("a_rst_hs", hs_a, 1);
        chk("a_rst_vs", vs_a, 1);     chk("a_rst_ls", ls_a, 0);
        chk("a_rst_fs", fs_a, 0);
        chk("b_rst_state", pack_b(), B_RESET);

        // Table-driven walk through the first lines of the default timing
        rst_a = 1'b0;
        pos = -1;
        for (int i = 0; i < 12; i++) begin
            while (pos < vecs[i].pos) begin
                step();
                pos++;
            end
            chk("a_vec_x", x_a, vecs[i].ex);
            chk("a_vec_y", y_a, vecs[i].ey);
            chk("a_vec_on", on_a, vecs[i].on);
            chk("a_vec_hs", hs_a, vecs[i].hs);
            chk("a_vec_vs", vs_a, vecs[i].vs);
            chk("a_vec_ls", ls_a, vecs[i].ls);
            chk("a_vec_fs", fs_a, vecs[i].fs);
            $display("vec %0d pos=%0d x=%0d y=%0d on=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
                     i, vecs[i].pos, x_a, y_a, on_a, hs_a, vs_a, ls_a, fs_a);
        end

        // Free-run A: line period, hsync window, onscreen drop
        rst_a = 1'b1; step(); rst_a = 1'b0;
        last_ls = -1; n_ls = 0; hs_t = 0; p_hs = 1'b1; p_on = 1'b0;
        for (int c = 0; c < 1700; c++) begin
            step();
            if (ls_a) begin
                if (last_ls >= 0) chk("a_line_period", c - last_ls, 800);
                last_ls = c; n_ls++;
            end
            if (p_hs && !hs_a) begin chk("a_hsync_start_x", x_a, 656); hs_t = c; end
            if (!p_hs && hs_a) chk("a_hsync_width", c - hs_t, 96);
            if (p_on && !on_a) chk("a_onscreen_drop_x", x_a, 640);
            p_hs = hs_a; p_on = on_a;
        end
        chk("a_line_count", n_ls, 3);
        $display("seq a_freerun lines=%0d", n_ls);

        // Free-run B: line/frame periods, active-high sync windows, vblank
        rst_b = 1'b1; step(); rst_b = 1'b0;
        last_ls = -1; last_fs = -1; n_ls = 0; n_fs = 0; hs_t = 0; vs_t = 0;
        p_hs = 1'b0; p_vs = 1'b0;
        for (int c = 0; c < 320; c++) begin
            step();
            if (ls_b) begin
                if (last_ls >= 0) chk("b_line_period", c - last_ls, BHT);
                last_ls = c; n_ls++;
            end
            if (fs_b) begin
                if (last_fs >= 0) chk("b_frame_period", c - last_fs, BHT * BVT);
                last_fs = c; n_fs++;
            end
            if (!p_hs && hs_b) begin chk("b_hsync_start_x", x_b, BHA + BHF); hs_t = c; end
            if (p_hs && !hs_b) chk("b_hsync_width", c - hs_t, BHS);
            if (!p_vs && vs_b) begin
                chk("b_vsync_start_y", y_b, BVA + BVF);
                chk("b_vsync_start_x", x_b, 0);
                vs_t = c;
            end
            if (p_vs && !vs_b) chk("b_vsync_width", c - vs_t, BHT * BVS);
            if (y_b >= BVA) chk("b_onscreen_vblank", on_b, 0);
            p_hs = hs_b; p_vs = vs_b;
        end
        chk("b_frame_count", n_fs, 3);
        $display("seq b_freerun lines=%0d frames=%0d", n_ls, n_fs);

        // Mid-frame reset on B at x=10, y=3
        rst_b = 1'b1; step(); rst_b = 1'b0;
        for (int c = 0; c <= 3 * BHT + 10; c++) step();
        chk("b_mid_x", x_b, 10);
        chk("b_mid_y", y_b, 3);
        rst_b = 1'b1; step();
        chk("b_mid_reset_state", pack_b(), B_RESET);
        rst_b = 1'b0; step();
        chk("b_mid_release", pack_b(), model_b(0));
        $display("seq b_midframe_reset x=%0d y=%0d fs=%0b", x_b, y_b, fs_b);

`ifdef VGA_PIX_CE_EN
        // A with pix_ce toggling 1,0: line of 1600 clk, outputs hold on ce=0
        rst_a = 1'b1; step(); rst_a = 1'b0;
        last_ls = -1; p_hs = 1'b0;
        begin
            logic [24:0] prev_a;
            prev_a = {x_a, y_a, on_a, hs_a, vs_a, ls_a, fs_a};
            for (int c = 0; c < 3300; c++) begin
                ce_a = (c % 2 == 0);
                step();
                if (!ce_a) chk("a_ce_hold", {x_a, y_a, on_a, hs_a, vs_a, ls_a, fs_a}, prev_a);
                if (ls_a && !p_hs) begin
                    if (last_ls >= 0) chk("a_ce_line_period", c - last_ls, 1600);
                    last_ls = c;
                end
                p_hs = ls_a;
                prev_a = {x_a, y_a, on_a, hs_a, vs_a, ls_a, fs_a};
            end
        end
        ce_a = 1'b1;
        $display("seq a_pix_ce_toggle done");
`endif

        // Randomised resets (and pix_ce) on B against the reference model
        m_out = B_RESET; m_pos = 0;
        for (int i = 0; i < 4000; i++) begin
            rst_b = (i == 0) || ($urandom_range(0, 299) == 0);
`ifdef VGA_PIX_CE_EN
            ce_b = ($urandom_range(0, 3) != 0);
`else
            ce_b = 1'b1;
`endif
            step();
            if (rst_b) begin
                m_out = B_RESET; m_pos = 0;
            end else if (ce_b) begin
                m_out = model_b(m_pos);
                m_pos = (m_pos + 1) % (BHT * BVT);
            end
            checks++;
            if (pack_b() !== m_out) begin
                errors++;
                $display("FAIL b_random cycle %0d: got %h expected %h", i, pack_b(), m_out);
            end
        end
        rst_b = 1'b0;
        $display("seq b_random cycles=4000");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
